sdram_upload: RTL

//  Read-back counterpart of the ROM/BIOS download path: streams 32-bit SDRAM words out to the
//  HPS ioctl upload port as 16-bit halfwords, low half first (mirror of the download packing).

---
 rtl/sdram_upload_pkg.sv | 26 ++
 rtl/sdram_upload_sync_2ff.sv | 22 ++
 rtl/sdram_upload.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/sdram_upload_pkg.sv
// Shared types and constants for the SDRAM upload (read-back) path.
package sdram_upload_pkg;

  localparam int unsigned ADDR_W = 25;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned IDX_W  = 6;

  localparam logic [IDX_W-1:0] UPLOAD_IDX_LO = 6'h00;
  localparam logic [IDX_W-1:0] UPLOAD_IDX_HI = 6'h01;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    SERVE,
    DRAIN
  } upload_state_t;

  // Range test written as an offset compare so a zero lower bound is not a constant compare.
  function automatic logic idx_in_range(input logic [IDX_W-1:0] idx,
                                        input logic [IDX_W-1:0] lo,
                                        input logic [IDX_W-1:0] hi);
    return ((7'(idx) - 7'(lo)) <= (7'(hi) - 7'(lo)));
  endfunction

endpackage

// File: rtl/sdram_upload_sync_2ff.sv
// Two-flop synchronizer for the SDRAM-domain read acknowledge toggle.
module sdram_upload_sync_2ff (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the async input through two flops; both clear on reset.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sdram_upload.sv
// Streams 32-bit SDRAM words to the HPS ioctl upload port as 16-bit halfwords,
// low half first, with one prefetched word. Optional running checksum of the
// emitted halfwords when UPLOAD_CKSUM_EN is defined.
module sdram_upload
  import sdram_upload_pkg::*;
#(
  parameter logic [IDX_W-1:0]  INDEX_LO  = UPLOAD_IDX_LO,
  parameter logic [IDX_W-1:0]  INDEX_HI  = UPLOAD_IDX_HI,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 25'h0000000
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_upload,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_rd,
  output logic [HALF_W-1:0] ioctl_din,
  output logic              ioctl_wait,
  output logic [ADDR_W-1:0] sdram_raddr,
  output logic              sdram_rd_req,
  input  logic              sdram_rd_ack,
  input  logic [WORD_W-1:0] sdram_dout,
`ifdef UPLOAD_CKSUM_EN
  output logic [HALF_W-1:0] cksum,
`endif
  output logic              upload_active
);

  upload_state_t     state;
  logic [WORD_W-1:0] word;
  logic [WORD_W-1:0] pf;
  logic              pf_valid;
  logic              half;
  logic              active_q;
  logic              restart_pend;
  logic              ack_s;
  logic              active_c;
  logic              ack_c;
  logic              start_c;
  logic              unused_idx;

  localparam logic [ADDR_W-1:0] BASE_ALIGNED = {BASE_ADDR[ADDR_W-1:2], 2'b00};
  localparam logic [ADDR_W-1:0] WORD_STEP    = ADDR_W'(4);

  assign unused_idx = ^ioctl_index[7:6];
  assign active_c   = ioctl_upload && idx_in_range(ioctl_index[5:0], INDEX_LO, INDEX_HI);
  assign ack_c      = (ack_s == sdram_rd_req);
  assign start_c    = (state == IDLE) && active_c && (!active_q || restart_pend);

  sdram_upload_sync_2ff u_ack_sync (
    .clk_sys (clk_sys),
    .reset   (reset),
    .d       (sdram_rd_ack),
    .q       (ack_s)
  );

  // Upload sequencer: fetch, serve halfwords with one-word prefetch, drain on abort.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      word          <= '0;
      pf            <= '0;
      pf_valid      <= 1'b0;
      half          <= 1'b0;
      active_q      <= 1'b0;
      restart_pend  <= 1'b0;
      ioctl_din     <= '0;
      ioctl_wait    <= 1'b0;
      sdram_raddr   <= '0;
      sdram_rd_req  <= 1'b0;
      upload_active <= 1'b0;
    end else begin
      active_q <= active_c;
      unique case (state)
        IDLE: begin
          if (start_c) begin
            sdram_raddr   <= BASE_ALIGNED;
            sdram_rd_req  <= ~sdram_rd_req;
            ioctl_wait    <= 1'b1;
            upload_active <= 1'b1;
            half          <= 1'b0;
            pf_valid      <= 1'b0;
            restart_pend  <= 1'b0;
            state         <= FETCH;
          end else if (!active_c) begin
            restart_pend <= 1'b0;
          end
        end
        FETCH, SERVE: begin
          if (!active_c) begin
            ioctl_wait <= 1'b0;
            if (ack_c) begin
              upload_active <= 1'b0;
              state         <= IDLE;
            end else begin
              state <= DRAIN;
            end
          end else if (state == FETCH) begin
            if (ack_c) begin
              word         <= sdram_dout;
              ioctl_din    <= sdram_dout[15:0];
              half         <= 1'b0;
              ioctl_wait   <= 1'b0;
              sdram_raddr  <= sdram_raddr + WORD_STEP;
              sdram_rd_req <= ~sdram_rd_req;
              pf_valid     <= 1'b0;
              state        <= SERVE;
            end
          end else if (ioctl_rd && half) begin
            if (pf_valid || ack_c) begin
              word         <= pf_valid ? pf : sdram_dout;
              ioctl_din    <= pf_valid ? pf[15:0] : sdram_dout[15:0];
              half         <= 1'b0;
              pf_valid     <= 1'b0;
              sdram_raddr  <= sdram_raddr + WORD_STEP;
              sdram_rd_req <= ~sdram_rd_req;
            end else begin
              ioctl_wait <= 1'b1;
              state      <= FETCH;
            end
          end else begin
            if (ioctl_rd) begin
              half      <= 1'b1;
              ioctl_din <= word[31:16];
            end
            if (ack_c && !pf_valid) begin
              pf       <= sdram_dout;
              pf_valid <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (active_c && !active_q) begin
            restart_pend <= 1'b1;
          end
          if (ack_c) begin
            upload_active <= 1'b0;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef UPLOAD_CKSUM_EN
  logic consume_c;
  assign consume_c = (state == SERVE) && active_c && ioctl_rd;

  // Running sum of every halfword handed out; restarts with each upload.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      cksum <= '0;
    end else if (start_c) begin
      cksum <= '0;
    end else if (consume_c) begin
      cksum <= cksum + ioctl_din;
    end
  end
`endif

endmodule
